// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 memory-side blocks.
// Contents:
//   MU0_ADDR_W   - default memory address width (matches the MU0 address bus)
//   MU0_DATA_W   - default memory word width
//   dump_state_e - state encoding of the mem_dump sequencer
package mu0_pkg;

    localparam int unsigned MU0_ADDR_W = 12;
    localparam int unsigned MU0_DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCap,
        StOut,
        StDone
    } dump_state_e;

endpackage

// File: rtl/mem_dump.sv
// mem_dump: reads an inclusive, possibly wrapping, address range from a
// single-port memory and presents each word on a valid/ready stream.
// Each word costs at least three cycles: a request cycle, a capture cycle and
// an output cycle that lasts until the consumer accepts the word.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start            - dump request, sampled only while idle
//   first_addr       - first word address, sampled with start
//   last_addr        - last word address (inclusive), sampled with start
//   memrq, rnw       - memory request / read-not-write (always a read)
//   mem_addr         - memory address, holds between requests
//   mem_rdata        - memory read data, valid one cycle after memrq
//   m_valid, m_ready - output stream handshake
//   m_data, m_addr   - dumped word and its address
//   busy             - dump in progress (non-idle)
//   done             - one-cycle pulse after the last word transfers
//   checksum         - running sum of transferred words
//
// Configuration: define MEM_DUMP_CHECKSUM_EN to build the checksum adder;
// otherwise checksum is tied to zero.
module mem_dump
    import mu0_pkg::*;
#(
    parameter int unsigned ADDR_W = MU0_ADDR_W,
    parameter int unsigned DATA_W = MU0_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              memrq,
    output logic              rnw,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    dump_state_e state_q, state_d;

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] m_data_q;
    logic [ADDR_W-1:0] m_addr_q;

    logic accept;
    logic xfer;

    assign accept = (state_q == StIdle) && start;
    assign xfer   = (state_q == StOut) && m_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StReq;
            StReq:  state_d = StCap;
            StCap:  state_d = StOut;
            StOut: begin
                if (m_ready) state_d = (cnt_q == last_q) ? StDone : StReq;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        memrq   = (state_q == StReq);
        rnw     = 1'b1;
        m_valid = (state_q == StOut);
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
    end

    // The address counter doubles as mem_addr: it only changes on the edge
    // that enters REQ, so the bus is stable whenever memrq is low. It is not
    // advanced after the last word, leaving mem_addr at the final address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            last_q   <= '0;
            m_data_q <= '0;
            m_addr_q <= '0;
        end else begin
            if (accept) begin
                cnt_q  <= first_addr;
                last_q <= last_addr;
            end else if (xfer && (cnt_q != last_q)) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
            if (state_q == StCap) begin
                m_data_q <= mem_rdata;
                m_addr_q <= cnt_q;
            end
        end
    end

    assign mem_addr = cnt_q;
    assign m_data   = m_data_q;
    assign m_addr   = m_addr_q;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_q + m_data_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: a memory model answers requests, a
// scoreboard holds the expected (addr, data) stream, and a monitor compares
// every accepted word, done pulse and hold-stability condition.
module tb_mem_dump;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          memrq;
    logic          rnw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    mem_dump #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .memrq     (memrq),
        .rnw       (rnw),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    int memrq_cnt = 0;
    int ready_mode = 0;
    int rcyc = 0;
    bit expect_done = 0;
    bit prev_hold = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: synchronous read, noise on the bus when not requested
    always @(posedge clk) begin
        if (memrq && rnw) mem_rdata <= mem[mem_addr];
        else mem_rdata <= DW'($urandom);
    end

    // Consumer ready pattern: 0 always, 1 toggle every 2 cycles, 2 random, 3 never
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = rcyc[1];
                2: m_ready = 1'($urandom % 2);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, between driving and capturing edges
    always @(negedge clk) begin
        if (rst) begin
            prev_hold   = 0;
            expect_done = 0;
        end else begin
            if (done) begin
                if (expect_done) done_count++;
                check("done_timing", {31'd0, done}, {31'd0, expect_done});
            end else if (expect_done) begin
                check("done_late", {31'd0, done}, 32'd1);
            end
            expect_done = 0;
            if (memrq) begin
                memrq_cnt++;
                check("rnw_with_memrq", {31'd0, rnw}, 32'd1);
            end
            if (prev_hold && m_valid) begin
                check("hold_data", {16'd0, m_data}, {16'd0, prev_data});
                check("hold_addr", {20'd0, m_addr}, {20'd0, prev_addr});
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_xfer", {20'd0, m_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("xfer_addr", {20'd0, m_addr}, {20'd0, e.addr});
                    check("xfer_data", {16'd0, m_data}, {16'd0, e.data});
                    check("busy_in_dump", {31'd0, busy}, 32'd1);
                    expect_done = e.last;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_addr = m_addr;
        end
    end

    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int mode, input bit inject);
        logic [AW-1:0] a;
        logic [DW-1:0] sum;
        int n;
        int d0;
        int cyc;
        a   = f;
        n   = 0;
        sum = '0;
        // Reference: walk the range modulo 2^AW, inclusive of last
        forever begin
            exp_t e;
            e.addr = a;
            e.data = mem[a];
            e.last = (a == l);
            sb.push_back(e);
            sum = sum + mem[a];
            n++;
            if (a == l) break;
            a = a + 1'b1;
        end
        ready_mode = mode;
        @(posedge clk);
        #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        d0         = done_count;
        memrq_cnt  = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (inject) begin
            repeat (4) @(posedge clk);
            #1;
            check("busy_at_inject", {31'd0, busy}, 32'd1);
            first_addr = AW'($urandom);
            last_addr  = AW'($urandom);
            start      = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        cyc = 0;
        while (done_count == d0 && cyc < n * 20 + 40) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done_count, d0 + 1);
        @(posedge clk);
        #1;
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("memrq_count", memrq_cnt, n);
        check("sb_empty", sb.size(), 0);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("checksum", {16'd0, checksum}, {16'd0, sum});
`else
        check("checksum_tied", {16'd0, checksum}, 32'd0);
`endif
        sb.delete();
    endtask

    initial begin
        bit seen;
        rst        = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

        repeat (2) @(negedge clk);
        check("rst_memrq", {31'd0, memrq}, 32'd0);
        check("rst_rnw", {31'd0, rnw}, 32'd1);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_m_addr", {20'd0, m_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_checksum", {16'd0, checksum}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic dump with ready always high
        mem[16] = 16'd8; mem[17] = 16'd0; mem[18] = 16'd0; mem[19] = 16'd1; mem[20] = 16'd1;
        run_dump(12'd16, 12'd20, 0, 0);
        // Same range with stalling consumer
        run_dump(12'd16, 12'd20, 1, 0);
        // Single word
        mem[5] = 16'h7000;
        run_dump(12'd5, 12'd5, 0, 0);
        // Wrap through the top of the address space
        run_dump(12'd4094, 12'd1, 2, 0);
        // Start while busy is ignored
        run_dump(12'd16, 12'd20, 0, 1);

        // Reset while a word is parked in OUT
        ready_mode = 3;
        @(posedge clk);
        #1;
        first_addr = 12'd30;
        last_addr  = 12'd33;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        check("reached_out", {31'd0, seen}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_memrq", {31'd0, memrq}, 32'd0);
        check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_m_data", {16'd0, m_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_dump(12'd30, 12'd33, 0, 0);

        // Randomized ranges and contents
        for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] f;
            logic [AW-1:0] l;
            f = (k % 3 == 0) ? AW'(12'd4090 + 12'($urandom_range(0, 5))) : AW'($urandom);
            l = f + AW'($urandom_range(0, 7));
            for (int j = 0; j < 8; j++) begin
                logic [AW-1:0] a;
                a = f + AW'(j);
                mem[a] = DW'($urandom);
            end
            run_dump(f, l, (k % 2 == 0) ? 2 : 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
